// File: rtl/stage_seq_ctrl.sv
// Stage sequencer for the EKF pipeline: accepts a one-hot stage request,
// optionally runs the nonlinear unit, then runs the systolic array, and
// reports completion, captured results and wait-state timeouts.
module stage_seq_ctrl #(
  parameter int                  N_STAGE = 3,
  parameter int                  DW      = 32,
  parameter int                  NRES    = 6,
  parameter logic [N_STAGE-1:0]  NL_MASK = '1,
  parameter int                  TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic [N_STAGE-1:0]   stage_val,
  output logic [N_STAGE-1:0]   stage_rdy,
  output logic [N_STAGE-1:0]   nl_init,
  input  logic [N_STAGE-1:0]   nl_done,
  input  logic [NRES*DW-1:0]   nl_result,
  output logic [NRES*DW-1:0]   res_bus,
  output logic                 res_valid,
  output logic                 arr_start,
  output logic [N_STAGE-1:0]   arr_stage,
  input  logic                 arr_done,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    NL_INIT  = 3'd1,
    NL_WAIT  = 3'd2,
    ARR_RUN  = 3'd3,
    ARR_WAIT = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Last timer value before a wait state gives up; unused when TIMEOUT is 0.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  state_t               state, nxt;
  logic [N_STAGE-1:0]   cur_stage, cur_nxt;
  logic [15:0]          timer;
  logic                 tmo_hit, nl_hit;
  logic                 req_ok, req_bad, tmo_nl, tmo_arr, capture;

  logic [N_STAGE-1:0]   stage_rdy_d, nl_init_d, arr_stage_d;
  logic                 arr_start_d, busy_d, err_d;
  logic [1:0]           err_code_d;

  function automatic logic is_onehot(input logic [N_STAGE-1:0] v);
    return (v != '0) && ((v & (v - N_STAGE'(1))) == '0);
  endfunction

  assign tmo_hit = TMO_EN && (timer == TMO_LAST);
  assign nl_hit  = |(nl_done & cur_stage);

  // State register, latched stage and wait-state timer.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      cur_stage <= '0;
      timer     <= '0;
    end else begin
      state     <= nxt;
      cur_stage <= cur_nxt;
      if ((state == NL_WAIT || state == ARR_WAIT) && nxt == state)
        timer <= timer + 16'd1;
      else
        timer <= '0;
    end
  end

  // Next-state decode; done beats timeout when both land on the same cycle.
  always_comb begin
    nxt     = state;
    cur_nxt = cur_stage;
    req_ok  = 1'b0;
    req_bad = 1'b0;
    tmo_nl  = 1'b0;
    tmo_arr = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (is_onehot(stage_val)) begin
          req_ok  = 1'b1;
          cur_nxt = stage_val;
          nxt     = ((NL_MASK & stage_val) != '0) ? NL_INIT : ARR_RUN;
        end else if (stage_val != '0) begin
          req_bad = 1'b1;
        end
      end
      NL_INIT: nxt = NL_WAIT;
      NL_WAIT: begin
        if (nl_hit) begin
          capture = 1'b1;
          nxt     = ARR_RUN;
        end else if (tmo_hit) begin
          tmo_nl = 1'b1;
          nxt    = IDLE;
        end
      end
      ARR_RUN: nxt = ARR_WAIT;
      ARR_WAIT: begin
        if (arr_done) begin
          nxt = DONE;
        end else if (tmo_hit) begin
          tmo_arr = 1'b1;
          nxt     = IDLE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output can be registered.
  always_comb begin
    nl_init_d   = (nxt == NL_INIT) ? cur_nxt : '0;
    arr_start_d = (nxt == ARR_RUN);
    arr_stage_d = (nxt == ARR_RUN || nxt == ARR_WAIT || nxt == DONE) ? cur_nxt : '0;
    stage_rdy_d = (nxt == DONE) ? cur_nxt : '0;
    busy_d      = (nxt != IDLE);
    err_d       = req_bad | tmo_nl | tmo_arr;
    err_code_d  = err_code;
    if (req_ok)       err_code_d = 2'b00;
    else if (req_bad) err_code_d = 2'b01;
    else if (tmo_nl)  err_code_d = 2'b10;
    else if (tmo_arr) err_code_d = 2'b11;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      nl_init   <= '0;
      arr_start <= 1'b0;
      arr_stage <= '0;
      stage_rdy <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      res_valid <= 1'b0;
    end else begin
      nl_init   <= nl_init_d;
      arr_start <= arr_start_d;
      arr_stage <= arr_stage_d;
      stage_rdy <= stage_rdy_d;
      busy      <= busy_d;
      err       <= err_d;
      err_code  <= err_code_d;
      res_valid <= capture;
    end
  end

  // Result capture; holds between captures and clears on reset.
  always_ff @(posedge clk) begin
    if (sys_rst)
      res_bus <= '0;
    else if (capture)
      res_bus <= nl_result;
  end

endmodule

// File: tb/tb_stage_seq_ctrl.sv
// Directed bench for stage_seq_ctrl: one instance with a short timeout and
// full nonlinear mask, one instance with stage 0 skipping the nonlinear step.
`timescale 1ns/1ps
module tb_stage_seq_ctrl;

  localparam int N = 3;
  localparam int DW = 32;
  localparam int NRES = 6;
  localparam logic [191:0] W16 = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [191:0] PA  = {6{32'hAAAA_0001}};
  localparam logic [191:0] PB  = {6{32'hBBBB_0002}};
  localparam logic [191:0] PC  = {6{32'hCCCC_0003}};

  logic clk = 1'b0;
  logic sys_rst;
  logic [N-1:0] nl_done;
  logic [NRES*DW-1:0] nl_result;

  logic [N-1:0] sv, stage_rdy, nl_init, arr_stage;
  logic [NRES*DW-1:0] res_bus;
  logic res_valid, arr_start, arr_done, busy, err;
  logic [1:0] err_code;

  logic [N-1:0] k_sv, k_stage_rdy, k_nl_init, k_arr_stage;
  logic [NRES*DW-1:0] k_res_bus;
  logic k_res_valid, k_arr_start, k_arr_done, k_busy, k_err;
  logic [1:0] k_err_code;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stage_seq_ctrl #(.N_STAGE(N), .DW(DW), .NRES(NRES), .NL_MASK(3'b111), .TIMEOUT(8)) u_dut (
    .clk(clk), .sys_rst(sys_rst), .stage_val(sv), .stage_rdy(stage_rdy),
    .nl_init(nl_init), .nl_done(nl_done), .nl_result(nl_result), .res_bus(res_bus),
    .res_valid(res_valid), .arr_start(arr_start), .arr_stage(arr_stage),
    .arr_done(arr_done), .busy(busy), .err(err), .err_code(err_code)
  );

  stage_seq_ctrl #(.N_STAGE(N), .DW(DW), .NRES(NRES), .NL_MASK(3'b110), .TIMEOUT(1024)) u_skip (
    .clk(clk), .sys_rst(sys_rst), .stage_val(k_sv), .stage_rdy(k_stage_rdy),
    .nl_init(k_nl_init), .nl_done(nl_done), .nl_result(nl_result), .res_bus(k_res_bus),
    .res_valid(k_res_valid), .arr_start(k_arr_start), .arr_stage(k_arr_stage),
    .arr_done(k_arr_done), .busy(k_busy), .err(k_err), .err_code(k_err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1; sv = '0; k_sv = '0; nl_done = '0; nl_result = '0;
    arr_done = 1'b0; k_arr_done = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_nl_init", nl_init, 0);
    chk("rst_arr_start", arr_start, 0);
    chk("rst_stage_rdy", stage_rdy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_res_bus", res_bus, 0);
    sys_rst = 1'b0;
    tick();

    // Predict stage at minimum latency
    sv = 3'b001; tick();
    sv = '0;
    chk("p_nl_init", nl_init, 3'b001);
    chk("p_busy", busy, 1);
    chk("p_arr_start_early", arr_start, 0);
    tick();
    chk("p_nl_init_pulse", nl_init, 0);
    nl_done = 3'b001; nl_result = W16; tick();
    nl_done = '0; nl_result = PC;
    chk("p_res_valid", res_valid, 1);
    chk("p_res_bus", res_bus, W16);
    chk("p_arr_start", arr_start, 1);
    chk("p_arr_stage", arr_stage, 3'b001);
    tick();
    chk("p_res_valid_pulse", res_valid, 0);
    chk("p_arr_start_pulse", arr_start, 0);
    chk("p_arr_stage_hold", arr_stage, 3'b001);
    chk("p_res_hold", res_bus, W16);
    arr_done = 1'b1; tick();
    arr_done = 1'b0;
    chk("p_stage_rdy", stage_rdy, 3'b001);
    chk("p_busy_done", busy, 1);
    tick();
    chk("p_stage_rdy_pulse", stage_rdy, 0);
    chk("p_busy_idle", busy, 0);
    chk("p_arr_stage_clr", arr_stage, 0);

    // Illegal request then a legal update request
    sv = 3'b011; tick();
    sv = '0;
    chk("ill_err", err, 1);
    chk("ill_err_code", err_code, 2'b01);
    chk("ill_busy", busy, 0);
    chk("ill_nl_init", nl_init, 0);
    tick();
    chk("ill_err_pulse", err, 0);
    chk("ill_err_code_hold", err_code, 2'b01);
    sv = 3'b100; tick();
    sv = '0;
    chk("u_err_code_clr", err_code, 2'b00);
    chk("u_nl_init", nl_init, 3'b100);
    tick();
    nl_done = 3'b001; nl_result = PA; tick();
    chk("u_foreign_done_valid", res_valid, 0);
    chk("u_foreign_done_bus", res_bus, W16);
    chk("u_foreign_done_start", arr_start, 0);
    nl_done = 3'b100; nl_result = PB; tick();
    nl_done = '0;
    chk("u_res_valid", res_valid, 1);
    chk("u_res_bus", res_bus, PB);
    chk("u_arr_stage", arr_stage, 3'b100);
    tick();
    arr_done = 1'b1; tick();
    arr_done = 1'b0;
    chk("u_stage_rdy", stage_rdy, 3'b100);
    tick();
    chk("u_busy_idle", busy, 0);

    // Nonlinear timeout (TIMEOUT=8)
    sv = 3'b010; tick();
    sv = '0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("nto_no_err", err, 0);
    end
    chk("nto_busy_before", busy, 1);
    tick();
    chk("nto_err", err, 1);
    chk("nto_err_code", err_code, 2'b10);
    chk("nto_busy", busy, 0);
    tick();
    chk("nto_err_pulse", err, 0);
    chk("nto_err_code_hold", err_code, 2'b10);

    // Array done on the timeout cycle wins
    sv = 3'b001; tick();
    sv = '0;
    chk("race_err_code_clr", err_code, 2'b00);
    tick();
    nl_done = 3'b001; nl_result = PA; tick();
    nl_done = '0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("race_busy_wait", busy, 1);
    arr_done = 1'b1; tick();
    arr_done = 1'b0;
    chk("race_stage_rdy", stage_rdy, 3'b001);
    chk("race_no_err", err, 0);
    tick();
    chk("race_no_err_after", err, 0);
    chk("race_err_code", err_code, 2'b00);

    // Array timeout
    sv = 3'b001; tick();
    sv = '0;
    tick();
    nl_done = 3'b001; tick();
    nl_done = '0;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("ato_err", err, 1);
    chk("ato_err_code", err_code, 2'b11);
    chk("ato_stage_rdy", stage_rdy, 0);

    // Skip-nonlinear instance: capture on stage 1, then skipped stage 0
    k_sv = 3'b010; tick();
    k_sv = '0;
    chk("k_nl_init", k_nl_init, 3'b010);
    tick();
    nl_done = 3'b010; nl_result = PC; tick();
    nl_done = '0; nl_result = PA;
    chk("k_res_bus", k_res_bus, PC);
    tick();
    k_arr_done = 1'b1; tick();
    k_arr_done = 1'b0;
    tick();
    k_sv = 3'b001; tick();
    k_sv = '0;
    chk("skip_nl_init", k_nl_init, 0);
    chk("skip_arr_start", k_arr_start, 1);
    chk("skip_arr_stage", k_arr_stage, 3'b001);
    tick();
    chk("skip_res_valid", k_res_valid, 0);
    k_arr_done = 1'b1; tick();
    k_arr_done = 1'b0;
    chk("skip_stage_rdy", k_stage_rdy, 3'b001);
    chk("skip_res_bus_held", k_res_bus, PC);

    // Reset during ARR_WAIT
    sv = 3'b001; tick();
    sv = '0;
    tick();
    nl_done = 3'b001; nl_result = PB; tick();
    nl_done = '0;
    tick(); tick();
    chk("mid_busy", busy, 1);
    sys_rst = 1'b1; tick();
    sys_rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_arr_stage", arr_stage, 0);
    chk("mrst_res_bus", res_bus, 0);
    chk("mrst_err_code", err_code, 0);
    arr_done = 1'b1; tick();
    arr_done = 1'b0;
    chk("mrst_late_stage_rdy", stage_rdy, 0);
    chk("mrst_late_busy", busy, 0);
    tick();
    chk("mrst_late_stage_rdy2", stage_rdy, 0);
    sv = 3'b010; tick();
    sv = '0;
    chk("post_rst_accept", nl_init, 3'b010);
    chk("post_rst_busy", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
